// File: rtl/axis_dpc_line_window_if.sv
// AXI4-Stream bundle used on both sides of the DPC line window.
interface axis_dpc_line_window_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_dpc_line_window.sv
// Vertical 5-row window generator feeding the DPC 5x5 core: 4 line RAMs, 1-cycle latency.
// Define AXIS_LINE_WINDOW_MIRROR_EN for mirrored borders instead of replicated edges.
module axis_dpc_line_window #(
  parameter int BITS      = 8,
  parameter int MAX_WIDTH = 4096
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [11:0]            max_x_index,
  input  logic [11:0]            max_y_index,
  axis_dpc_line_window_if.slave  s_axis,
  axis_dpc_line_window_if.master m_axis,
  output logic                   err_line_len
);
  localparam int AW = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;
  state_t state, state_next;

  logic [11:0]          x, y, mx, my;
  logic                 ready_en;
  logic                 out_valid, out_last, out_user;
  logic [4:0][2:0]      sel_q, sel_next;
  logic [BITS-1:0]      pix_q;
  logic [3:0][BITS-1:0] rd_data;
  logic [5*BITS-1:0]    column;
  logic                 out_free, s_ready, s_fire, sof, x_last, we, issue;
  logic [11:0]          wr_x;
  logic [1:0]           wr_ring;
  logic signed [12:0]   row_base, row_max, row_cur, row_src;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    we         = 1'b0;
    issue      = 1'b0;
    out_free   = ~out_valid | m_axis.tready;
    x_last     = (x == mx);
    case (state)
      S_IDLE, S_FILL: s_ready = ready_en;
      S_RUN:          s_ready = out_free;
      default:        s_ready = 1'b0;
    endcase
    s_fire = s_axis.tvalid & s_ready;
    sof    = s_fire & s_axis.tuser;
    case (state)
      S_IDLE: begin
        we = sof;
        if (sof) state_next = S_FILL;
      end
      S_FILL: begin
        we = s_fire;
        if (sof) state_next = S_FILL;
        else if (s_fire && x_last && y == 12'd1) state_next = S_RUN;
      end
      S_RUN: begin
        we    = s_fire;
        issue = s_fire & ~s_axis.tuser;
        if (sof) state_next = S_FILL;
        else if (s_fire && x_last && y == my) state_next = S_FLUSH;
      end
      default: begin
        issue = out_free;
        if (out_free && x_last && y == my + 12'd2) state_next = S_IDLE;
      end
    endcase
  end

  assign wr_x    = sof ? 12'd0 : x;
  assign wr_ring = sof ? 2'd0 : y[1:0];

  // Counter y runs two rows ahead of the emitted row; in flush it walks past the last input row.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en     <= 1'b0;
      x            <= '0;
      y            <= '0;
      mx           <= '0;
      my           <= '0;
      err_line_len <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (sof) begin
        mx           <= max_x_index;
        my           <= max_y_index;
        x            <= 12'd1;
        y            <= '0;
        err_line_len <= (state == S_IDLE) ? (s_axis.tlast != (max_x_index == 12'd0)) : 1'b1;
      end else if (we || issue) begin
        x <= x_last ? 12'd0 : x + 12'd1;
        if (x_last) y <= y + 12'd1;
        if (state != S_FLUSH && s_axis.tlast != x_last) err_line_len <= 1'b1;
      end
    end
  end

  // Map each tap to a ring slot, or to the live input pixel (code 4) for the newest row.
  always_comb begin
    row_max  = signed'({1'b0, my});
    row_cur  = signed'({1'b0, y});
    row_base = row_cur - 13'sd4;
    row_src  = '0;
    sel_next = '0;
    for (int k = 0; k < 5; k++) begin
      row_src = row_base + 13'(k);
`ifdef AXIS_LINE_WINDOW_MIRROR_EN
      if (row_src < 0)            row_src = -row_src;
      else if (row_src > row_max) row_src = row_max + row_max - row_src;
`else
      if (row_src < 0)            row_src = '0;
      else if (row_src > row_max) row_src = row_max;
`endif
      sel_next[k] = (state == S_RUN && row_src == row_cur) ? 3'd4 : {1'b0, row_src[1:0]};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      sel_q     <= '0;
      pix_q     <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_last  <= x_last;
      out_user  <= (state == S_RUN) && (y == 12'd2) && (x == 12'd0);
      sel_q     <= sel_next;
      pix_q     <= s_axis.tdata;
    end else if (m_axis.tready || (sof && state == S_RUN)) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end
  end

  // Read-first RAMs: the slot being overwritten still yields row y-4 on the same cycle.
  for (genvar i = 0; i < 4; i++) begin : g_line
    logic [BITS-1:0] mem [MAX_WIDTH];
    logic [BITS-1:0] q;
    always_ff @(posedge aclk) begin
      if (we && wr_ring == 2'(i)) mem[wr_x[AW-1:0]] <= s_axis.tdata;
      if (issue) q <= mem[x[AW-1:0]];
    end
    assign rd_data[i] = q;
  end

  always_comb begin
    column = '0;
    for (int k = 0; k < 5; k++)
      column[BITS*k +: BITS] = sel_q[k][2] ? pix_q : rd_data[sel_q[k][1:0]];
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;
  assign m_axis.tdata  = out_valid ? column : '0;
endmodule

// File: tb/tb_axis_dpc_line_window.sv
// Randomised self-checking bench for axis_dpc_line_window against a frame-level window model.
module tb_axis_dpc_line_window;
  localparam int BITS = 8;

`ifdef AXIS_LINE_WINDOW_MIRROR_EN
  localparam logic [39:0] BEAT_0_3 = 40'h23_13_03_13_23;
  localparam logic [39:0] BEAT_5_7 = 40'h37_47_57_47_37;
`else
  localparam logic [39:0] BEAT_0_3 = 40'h23_13_03_03_03;
  localparam logic [39:0] BEAT_5_7 = 40'h57_57_57_47_37;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [11:0] max_x_index, max_y_index;
  logic        err_line_len;

  axis_dpc_line_window_if #(.W(BITS))   s_if ();
  axis_dpc_line_window_if #(.W(5*BITS)) m_if ();

  axis_dpc_line_window #(.BITS(BITS), .MAX_WIDTH(4096)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .max_x_index (max_x_index),
    .max_y_index (max_y_index),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .err_line_len(err_line_len)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [7:0]  d; logic l; logic u; } in_beat_t;
  typedef struct { logic [39:0] d; logic l; logic u; } out_beat_t;

  in_beat_t  in_q[$];
  out_beat_t exp_q[$];
  out_beat_t got_q[$];
  logic [7:0] img [0:15][0:15];
  int checks   = 0;
  int failures = 0;

  function automatic int clamp_row(input int t, input int h);
`ifdef AXIS_LINE_WINDOW_MIRROR_EN
    if (t < 0)     return -t;
    if (t > h - 1) return 2 * (h - 1) - t;
`else
    if (t < 0)     return 0;
    if (t > h - 1) return h - 1;
`endif
    return t;
  endfunction

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic set_size(input int w, input int h);
    max_x_index = 12'(w - 1);
    max_y_index = 12'(h - 1);
  endtask

  task automatic make_image(input int w, input int h, input bit pattern);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        img[yy][xx] = pattern ? 8'(yy * 16 + xx) : 8'($urandom);
  endtask

  task automatic push_input(input int w, input int count, input int bad_row, input int bad_x);
    in_beat_t b;
    for (int i = 0; i < count; i++) begin
      int r, c;
      r = i / w;
      c = i % w;
      b.d = img[r][c];
      b.l = (r == bad_row) ? (c == bad_x) : (c == w - 1);
      b.u = (i == 0);
      in_q.push_back(b);
    end
  endtask

  task automatic push_expected(input int w, input int h, input int count);
    out_beat_t b;
    for (int i = 0; i < count; i++) begin
      int r, c;
      r = i / w;
      c = i % w;
      for (int k = 0; k < 5; k++) b.d[8*k +: 8] = img[clamp_row(r - 2 + k, h)][c];
      b.l = (c == w - 1);
      b.u = (i == 0);
      exp_q.push_back(b);
    end
  endtask

  // err_idx: -2 no err checks, -1 err must stay low, n err must rise once input beat n is taken.
  task automatic stream(input int vpct, input int rpct, input int err_idx,
                        input int stop_after, output int low_cycles);
    int        acc, cyc, stop_cnt;
    bit        taken;
    logic      exp_err;
    out_beat_t g;
    acc = 0; cyc = 0; taken = 1'b0; stop_cnt = stop_after; low_cycles = 0;
    while (in_q.size() > 0 || exp_q.size() > 0) begin
      @(negedge aclk);
      if (taken) begin
        void'(in_q.pop_front());
        s_if.tvalid = 1'b0;
        acc++;
        taken = 1'b0;
      end
      if (stop_cnt >= 0 && in_q.size() == 0) begin
        if (stop_cnt == 0) break;
        stop_cnt--;
      end
      cyc++;
      if (cyc > 5000) begin
        checks++; failures++;
        $display("[TB] FAIL stream_timeout: got=%0d beats outstanding exp=0", exp_q.size());
        break;
      end
      m_if.tready = ($urandom_range(99) < rpct);
      if (!s_if.tvalid && in_q.size() > 0 && $urandom_range(99) < vpct) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = in_q[0].d;
        s_if.tlast  = in_q[0].l;
        s_if.tuser  = in_q[0].u;
      end
      #1;
      if (!s_if.tready) low_cycles++;
      if (err_idx != -2 && acc > 0) begin
        exp_err = (err_idx >= 0 && acc > err_idx);
        checks++;
        if (err_line_len !== exp_err) begin
          failures++;
          $display("[TB] FAIL err_line_len after %0d inputs: got=%b exp=%b", acc, err_line_len, exp_err);
        end
      end
      if (m_if.tvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL extra_beat: got=%h exp=none", m_if.tdata);
        end else if (m_if.tdata !== exp_q[0].d || m_if.tlast !== exp_q[0].l || m_if.tuser !== exp_q[0].u) begin
          failures++;
          $display("[TB] FAIL beat%0d: got=%h/%b/%b exp=%h/%b/%b", got_q.size(),
                   m_if.tdata, m_if.tlast, m_if.tuser, exp_q[0].d, exp_q[0].l, exp_q[0].u);
        end
        if (m_if.tready) begin
          g.d = m_if.tdata; g.l = m_if.tlast; g.u = m_if.tuser;
          got_q.push_back(g);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (s_if.tvalid && s_if.tready) taken = 1'b1;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready, err_line_len} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL %s_ctrl: got=%b exp=00000", name,
               {m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready, err_line_len});
    end
    checks++;
    if (m_if.tdata !== 40'h0) begin
      failures++;
      $display("[TB] FAIL %s_tdata: got=%h exp=0", name, m_if.tdata);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_idle_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_frame_pattern();
    int low;
    $display("[TB] test_frame_pattern");
    clear_queues();
    set_size(8, 6);
    make_image(8, 6, 1'b1);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(100, 100, -1, -1, low);
    check_count("flush_tready_low", low, 16);
    check_count("pattern_beats", got_q.size(), 48);
    if (got_q.size() >= 48) begin
      checks++;
      if (got_q[3].d !== BEAT_0_3) begin
        failures++;
        $display("[TB] FAIL beat_0_3: got=%h exp=%h", got_q[3].d, BEAT_0_3);
      end
      checks++;
      if (got_q[47].d !== BEAT_5_7) begin
        failures++;
        $display("[TB] FAIL beat_5_7: got=%h exp=%h", got_q[47].d, BEAT_5_7);
      end
    end
  endtask

  task automatic test_backpressure();
    int low;
    $display("[TB] test_backpressure");
    clear_queues();
    set_size(8, 6);
    make_image(8, 6, 1'b1);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(60, 50, -1, -1, low);
    check_count("backpressure_beats", got_q.size(), 48);
  endtask

  task automatic test_random_frames();
    int low, w, h;
    $display("[TB] test_random_frames");
    for (int n = 0; n < 4; n++) begin
      w = $urandom_range(12, 2);
      h = $urandom_range(10, 3);
      clear_queues();
      set_size(w, h);
      make_image(w, h, 1'b0);
      push_input(w, w * h, -1, -1);
      push_expected(w, h, w * h);
      stream(70, 60, -1, -1, low);
      check_count("random_beats", got_q.size(), w * h);
    end
  endtask

  task automatic test_line_len();
    int low;
    $display("[TB] test_line_len");
    clear_queues();
    set_size(8, 6);
    make_image(8, 6, 1'b1);
    push_input(8, 48, 3, 5);
    push_expected(8, 6, 48);
    stream(100, 100, 3 * 8 + 5, -1, low);
    check_count("line_len_beats", got_q.size(), 48);
    check_count("line_len_err_sticky", int'(err_line_len), 1);
    clear_queues();
    make_image(8, 6, 1'b0);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(80, 70, -1, -1, low);
    check_count("line_len_next_beats", got_q.size(), 48);
  endtask

  task automatic test_sof_inject();
    int low;
    $display("[TB] test_sof_inject");
    clear_queues();
    set_size(8, 6);
    make_image(8, 6, 1'b1);
    push_input(8, 3 * 8 + 4, -1, -1);
    push_expected(8, 6, 3 * 8 + 4 - 2 * 8);
    make_image(8, 6, 1'b0);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(80, 100, 3 * 8 + 4, -1, low);
    check_count("sof_total_beats", got_q.size(), 12 + 48);
    if (got_q.size() > 12) check_count("sof_new_tuser", int'(got_q[12].u), 1);
    check_count("sof_err", int'(err_line_len), 1);
  endtask

  task automatic test_reset_flush();
    int low;
    $display("[TB] test_reset_flush");
    clear_queues();
    set_size(8, 6);
    make_image(8, 6, 1'b1);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(100, 100, -1, 4, low);
    clear_queues();
    #2;
    aresetn = 1'b0;
    #1;
    check_idle_zero("flush_reset");
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    make_image(8, 6, 1'b0);
    push_input(8, 48, -1, -1);
    push_expected(8, 6, 48);
    stream(100, 100, -1, -1, low);
    check_count("after_reset_beats", got_q.size(), 48);
  endtask

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b0;
    max_x_index = 12'd7;
    max_y_index = 12'd5;
    test_reset();
    test_frame_pattern();
    test_backpressure();
    test_random_frames();
    test_line_len();
    test_sof_inject();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_dpc_line_window.md
Name: axis_dpc_line_window

Overview:
- Vertical 5-row window generator directly upstream of the DPC 5x5 core.
- Buffers 4 lines of a raw Bayer AXIS stream and emits, per pixel, a column of 5 vertically adjacent pixels with rows r-2..r+2 centred on output row r.
- Top and bottom borders are clamped, so the downstream horizontal shift stage always receives exactly height × width beats.
- Tail lines are flushed internally at end of frame.

Parameters:
- BITS, 8, pixel width.
- MAX_WIDTH, 4096, line RAM depth (4 RAMs × MAX_WIDTH × BITS); max_x_index < MAX_WIDTH.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- max_x_index  in  12  width-1, sampled at SOF; width ≥ 2
- max_y_index  in  12  height-1, sampled at SOF; height ≥ 3
- s_axis_tdata  in  BITS  pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  EOL
- s_axis_tuser  in  1  SOF
- m_axis_tdata  out  5*BITS  slice k = [BITS*k +: BITS] is row clamp(r-2+k), k=0 top
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  EOL at output x == width-1
- m_axis_tuser  out  1  SOF at output (0,0)
- err_line_len  out  1  sticky: input tlast position ≠ max_x_index; cleared at SOF

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0. Line RAM contents are don't-care. Reset mid-frame aborts the frame.
- S_IDLE:
  - s_axis_tready=1.
  - Beats without tuser are dropped.
  - A beat with tuser latches widths, writes pixel (0,0), and moves to S_FILL.
- S_FILL (input rows 0..1):
  - s_axis_tready=1; written to RAM only, no output.
  - On the last pixel of row 1, go to S_RUN.
- S_RUN (input rows 2..H-1):
  - Input pixel (y,x) is written to RAM[y mod 4] at x, and RAMs are read at x in the same cycle.
  - Output row r = y-2. The output register loads the column one cycle after the input handshake, so latency is 1 cycle.
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (single output register, no bubble at full throughput).
  - After input row H-1 completes, go to S_FLUSH.
- S_FLUSH:
  - s_axis_tready=0.
  - Internal x/row counters generate output rows H-2 and H-1 from RAM, one beat per cycle while the output register is free.
  - After the last beat (H-1, width-1) is accepted, go to S_IDLE.
- Clamping:
  - Row index < 0 maps to 0; > H-1 maps to H-1.
  - Row r=0 outputs {row0, row0, row0, row1, row2}; row H-1 outputs {H-3, H-2, H-1, H-1, H-1}.
- Line length:
  - Input x wraps at max_x_index regardless of s_axis_tlast.
  - A mismatch sets err_line_len.
  - m_axis_tlast is generated from the internal x counter, never forwarded.
- tuser mid-frame (S_FILL/S_RUN):
  - Abort the current frame and drop the pending output beat.
  - Treat the beat as (0,0) of a new frame in S_FILL.
  - Set err_line_len.
- tuser during S_FLUSH: not accepted (tready=0); it is taken when S_IDLE is reached.
- Backpressure: with m_axis_tready=0, m_axis_tvalid/tdata/tlast/tuser hold stable. No RAM write occurs without an input handshake.
- Row indices are 12-bit; the ring index is y[1:0]; row clamps are computed in 13-bit signed arithmetic.

Optional Feature:
- AXIS_LINE_WINDOW_MIRROR_EN
- Defined: borders mirror without edge repeat: row -1→1, -2→2, H→H-2, H+1→H-3. Row 0 outputs {row2, row1, row0, row1, row2}.
- Undefined: replicate clamp as above.
- Port list and latency are identical in both builds.

Test Plan:
- 8x6 frame, pixel = y*16+x, tready=1, continuous valid:
  - 48 output beats.
  - Beat (0,3) = {03,03,03,13,23}.
  - Beat (5,7) = {37,47,57,57,57}.
  - tuser only on beat 0; tlast on every 8th beat.
  - s_axis_tready=0 for exactly 16 cycles of flush.
- Same frame with MIRROR_EN:
  - Beat (0,3) = {23,13,03,13,23}.
  - Beat (5,7) = {37,47,57,47,37}.
- Random m_axis_tready (50%) and random s_axis_tvalid:
  - Output sequence identical to the previous run.
  - No beat lost or duplicated; data stable while stalled.
- Row 3 of 8x6 with tlast at x=5:
  - err_line_len=1 from that cycle.
  - Output still 48 beats with tlast at x=7.
  - err clears at next SOF.
- tuser injected at (3,4):
  - Old frame aborted.
  - New 8x6 frame outputs 48 correct beats starting with tuser.
  - err_line_len=1.
- aresetn asserted mid S_FLUSH, then a new frame:
  - All outputs 0 immediately.
  - Next frame outputs correct 48 beats.
